// File: rtl/game_sequencer.sv
// rtl/game_sequencer.sv - Simon Says central game FSM
// Sequences gen/display/wait/check, owns the round counter and the player timeout.
module game_sequencer #(
   parameter int            MAX_ROUNDS     = 16,
   parameter int            TW             = 24,
   parameter logic [TW-1:0] TIMEOUT_CYCLES = 24'd5000000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       soft_clear,
   input  logic       start_btn,
   input  logic       gen_done,
   input  logic       disp_done,
   input  logic       wait_done,
   input  logic       check_done,
   input  logic       check_pass,
   input  logic       button_any,
   output logic       gen_start,
   output logic       disp_start,
   output logic       wait_start,
   output logic       check_start,
   output logic [3:0] round,
   output logic [1:0] state_dbg,
   output logic       game_over,
   output logic       game_won,
   output logic       timeout
);

   typedef enum logic [2:0] {S_IDLE, S_GEN, S_DISP, S_WAIT, S_CHECK, S_END} state_t;

   // Five bits so that a final round of 16 is still distinguishable from 0.
   localparam logic [4:0]    MAX_R    = 5'(MAX_ROUNDS);
   localparam logic [TW-1:0] TMO_LAST = TIMEOUT_CYCLES - 1'b1;

   state_t        state_q;
   logic [4:0]    round_q;
   logic [TW-1:0] timer_q;
   logic [TW-1:0] timer_d;
   logic          start_prev_q;
   logic          start_edge;
   logic          gen_start_q, disp_start_q, wait_start_q, check_start_q;
   logic [1:0]    dbg_q;
   logic          over_q, won_q, tmo_q;

   assign start_edge = start_btn & ~start_prev_q;
   assign timer_d    = (timer_q == '1) ? timer_q : timer_q + 1'b1;

   always_ff @(posedge clk) begin
      if (!rst_n || soft_clear) begin
         state_q       <= S_IDLE;
         round_q       <= '0;
         timer_q       <= '0;
         start_prev_q  <= 1'b1;
         gen_start_q   <= 1'b0;
         disp_start_q  <= 1'b0;
         wait_start_q  <= 1'b0;
         check_start_q <= 1'b0;
         dbg_q         <= 2'b00;
         over_q        <= 1'b0;
         won_q         <= 1'b0;
         tmo_q         <= 1'b0;
      end else begin
         start_prev_q  <= start_btn;
         gen_start_q   <= 1'b0;
         disp_start_q  <= 1'b0;
         wait_start_q  <= 1'b0;
         check_start_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start_edge) begin
                  state_q     <= S_GEN;
                  gen_start_q <= 1'b1;
               end
            end
            S_GEN: begin
               if (gen_done) begin
                  state_q      <= S_DISP;
                  disp_start_q <= 1'b1;
                  round_q      <= 5'd1;
                  dbg_q        <= 2'b01;
               end
            end
            S_DISP: begin
               if (disp_done) begin
                  state_q      <= S_WAIT;
                  wait_start_q <= 1'b1;
                  timer_q      <= '0;
                  dbg_q        <= 2'b10;
               end
            end
            S_WAIT: begin
               // A completed entry wins over an expiring timer in the same cycle.
               if (wait_done) begin
                  state_q       <= S_CHECK;
                  check_start_q <= 1'b1;
                  dbg_q         <= 2'b11;
               end else if (button_any) begin
                  timer_q <= '0;
               end else if (timer_q == TMO_LAST) begin
                  state_q <= S_END;
                  over_q  <= 1'b1;
                  won_q   <= 1'b0;
                  tmo_q   <= 1'b1;
                  dbg_q   <= 2'b00;
               end else begin
                  timer_q <= timer_d;
               end
            end
            S_CHECK: begin
               if (check_done) begin
                  if (!check_pass || round_q == MAX_R) begin
                     state_q <= S_END;
                     over_q  <= 1'b1;
                     won_q   <= check_pass;
                     dbg_q   <= 2'b00;
                  end else begin
                     state_q      <= S_DISP;
                     disp_start_q <= 1'b1;
                     round_q      <= round_q + 1'b1;
                     dbg_q        <= 2'b01;
                  end
               end
            end
            S_END: begin
               if (start_edge) begin
                  state_q     <= S_GEN;
                  gen_start_q <= 1'b1;
                  round_q     <= '0;
                  over_q      <= 1'b0;
                  won_q       <= 1'b0;
                  tmo_q       <= 1'b0;
               end
            end
            default: begin
               state_q <= S_IDLE;
               dbg_q   <= 2'b00;
            end
         endcase
      end
   end

   assign gen_start   = gen_start_q;
   assign disp_start  = disp_start_q;
   assign wait_start  = wait_start_q;
   assign check_start = check_start_q;
   assign round       = round_q[3:0];
   assign state_dbg   = dbg_q;
   assign game_over   = over_q;
   assign game_won    = won_q;
   assign timeout     = tmo_q;

endmodule

// File: tb/tb_game_sequencer.sv
// tb/tb_game_sequencer.sv - directed self-checking bench for game_sequencer
module tb_game_sequencer;

   logic       clk = 1'b0;
   logic       rst_n, soft_clear, start_btn;
   logic       gen_done, disp_done, wait_done, check_done, check_pass, button_any;
   logic       gen_start, disp_start, wait_start, check_start;
   logic [3:0] round;
   logic [1:0] state_dbg;
   logic       game_over, game_won, timeout;

   int checks = 0;
   int errors = 0;

   game_sequencer #(
      .MAX_ROUNDS    (3),
      .TW            (24),
      .TIMEOUT_CYCLES(24'd8)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .soft_clear (soft_clear),
      .start_btn  (start_btn),
      .gen_done   (gen_done),
      .disp_done  (disp_done),
      .wait_done  (wait_done),
      .check_done (check_done),
      .check_pass (check_pass),
      .button_any (button_any),
      .gen_start  (gen_start),
      .disp_start (disp_start),
      .wait_start (wait_start),
      .check_start(check_start),
      .round      (round),
      .state_dbg  (state_dbg),
      .game_over  (game_over),
      .game_won   (game_won),
      .timeout    (timeout)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic press();
      start_btn = 1'b0;
      tick();
      start_btn = 1'b1;
      tick();
      chk("press_gen_start", 32'(gen_start), 32'd1);
      chk("press_round", 32'(round), 32'd0);
      chk("press_over", 32'(game_over), 32'd0);
      chk("press_won", 32'(game_won), 32'd0);
      chk("press_tmo", 32'(timeout), 32'd0);
   endtask

   task automatic pulse_gen();
      gen_done = 1'b1;
      tick();
      gen_done = 1'b0;
      chk("gen_to_disp", 32'(disp_start), 32'd1);
      chk("gen_round", 32'(round), 32'd1);
      chk("gen_dbg", 32'(state_dbg), 32'd1);
   endtask

   task automatic pulse_disp();
      disp_done = 1'b1;
      tick();
      disp_done = 1'b0;
      chk("disp_to_wait", 32'(wait_start), 32'd1);
      chk("wait_dbg", 32'(state_dbg), 32'd2);
   endtask

   task automatic pulse_wait();
      wait_done = 1'b1;
      tick();
      wait_done = 1'b0;
      chk("wait_to_check", 32'(check_start), 32'd1);
      chk("check_dbg", 32'(state_dbg), 32'd3);
   endtask

   task automatic pulse_check(input logic pass);
      check_done = 1'b1;
      check_pass = pass;
      tick();
      check_done = 1'b0;
      check_pass = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; soft_clear = 1'b0; start_btn = 1'b1;
      gen_done = 1'b0; disp_done = 1'b0; wait_done = 1'b0;
      check_done = 1'b0; check_pass = 1'b0; button_any = 1'b0;

      // Reset with start held: releasing reset must not start a game.
      tick();
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rst_gen_start", 32'(gen_start), 32'd0);
      end
      chk("rst_dbg", 32'(state_dbg), 32'd0);
      chk("rst_round", 32'(round), 32'd0);
      chk("rst_over", 32'(game_over), 32'd0);
      chk("rst_won", 32'(game_won), 32'd0);
      chk("rst_tmo", 32'(timeout), 32'd0);

      // Full winning game, three rounds.
      press();
      pulse_gen();
      for (int r = 1; r <= 3; r++) begin
         tick();
         chk("disp_pulse_low", 32'(disp_start), 32'd0);
         chk("disp_hold_dbg", 32'(state_dbg), 32'd1);
         pulse_disp();
         pulse_wait();
         pulse_check(1'b1);
         if (r < 3) begin
            chk("pass_disp_start", 32'(disp_start), 32'd1);
            chk("pass_round", 32'(round), 32'(r + 1));
         end
      end
      chk("win_over", 32'(game_over), 32'd1);
      chk("win_won", 32'(game_won), 32'd1);
      chk("win_round", 32'(round), 32'd3);
      chk("win_tmo", 32'(timeout), 32'd0);
      chk("win_dbg", 32'(state_dbg), 32'd0);

      // Lose in round 2.
      press();
      pulse_gen();
      pulse_disp();
      pulse_wait();
      pulse_check(1'b1);
      chk("lose_r2", 32'(round), 32'd2);
      pulse_disp();
      pulse_wait();
      pulse_check(1'b0);
      chk("lose_over", 32'(game_over), 32'd1);
      chk("lose_won", 32'(game_won), 32'd0);
      chk("lose_tmo", 32'(timeout), 32'd0);
      chk("lose_round", 32'(round), 32'd2);

      // Quiet WAIT: eight cycles then timeout.
      press();
      pulse_gen();
      pulse_disp();
      for (int i = 0; i < 7; i++) tick();
      chk("tmo_pre_dbg", 32'(state_dbg), 32'd2);
      chk("tmo_pre_over", 32'(game_over), 32'd0);
      tick();
      chk("tmo_over", 32'(game_over), 32'd1);
      chk("tmo_flag", 32'(timeout), 32'd1);
      chk("tmo_won", 32'(game_won), 32'd0);
      chk("tmo_round", 32'(round), 32'd1);
      chk("tmo_dbg", 32'(state_dbg), 32'd0);

      // Button at WAIT cycle 5 restarts the count.
      press();
      pulse_gen();
      pulse_disp();
      for (int i = 0; i < 5; i++) tick();
      button_any = 1'b1;
      tick();
      button_any = 1'b0;
      for (int i = 0; i < 7; i++) tick();
      chk("btn_still_wait", 32'(state_dbg), 32'd2);
      chk("btn_no_over", 32'(game_over), 32'd0);
      tick();
      chk("btn_tmo", 32'(timeout), 32'd1);
      chk("btn_over", 32'(game_over), 32'd1);

      // wait_done on the expiry cycle wins.
      press();
      pulse_gen();
      pulse_disp();
      for (int i = 0; i < 7; i++) tick();
      pulse_wait();
      chk("prio_tmo", 32'(timeout), 32'd0);
      chk("prio_over", 32'(game_over), 32'd0);

      // soft_clear mid-DISP together with disp_done.
      pulse_check(1'b1);
      chk("sc_pre_round", 32'(round), 32'd2);
      soft_clear = 1'b1;
      disp_done  = 1'b1;
      tick();
      soft_clear = 1'b0;
      disp_done  = 1'b0;
      chk("sc_dbg", 32'(state_dbg), 32'd0);
      chk("sc_round", 32'(round), 32'd0);
      chk("sc_wait_start", 32'(wait_start), 32'd0);
      tick();
      chk("sc_wait_start2", 32'(wait_start), 32'd0);

      // Stray done pulses in IDLE are ignored.
      gen_done = 1'b1; check_done = 1'b1; check_pass = 1'b1;
      tick();
      gen_done = 1'b0; check_done = 1'b0; check_pass = 1'b0;
      tick();
      chk("idle_dbg", 32'(state_dbg), 32'd0);
      chk("idle_disp_start", 32'(disp_start), 32'd0);
      chk("idle_gen_start", 32'(gen_start), 32'd0);
      chk("idle_round", 32'(round), 32'd0);
      chk("idle_over", 32'(game_over), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
